// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single 256-bit Data_Memory port between the
// instruction-cache refill path (m0) and the dcache controller (m1).
// One whole transaction is granted at a time. The grant is held until the
// memory acknowledges, and then one RELEASE cycle follows. A watchdog forces a
// zero-data ack and sets a sticky error if the memory never answers.
// Optional feature: define ARB_ROUND_ROBIN_EN to get round-robin tie-breaking.
// Without it, m1 always wins ties.
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 256,
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_enable_i,
  input  logic              m0_write_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_data_i,
  output logic              m0_ack_o,
  output logic [DATA_W-1:0] m0_data_o,
  input  logic              m1_enable_i,
  input  logic              m1_write_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_data_i,
  output logic              m1_ack_o,
  output logic [DATA_W-1:0] m1_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic              grant_o,
  output logic              err_o
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BUSY    = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  localparam logic             WD_EN       = (TIMEOUT_CYC > 0);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);

  logic [1:0]        state_q, state_d;
  logic              mem_enable_q, mem_enable_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic              grant_q, grant_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              any_req;
  logic              winner;
  logic              in_busy;
  logic              timeout;
  logic              done;
  logic [DATA_W-1:0] rsp_data;

  assign any_req = m0_enable_i | m1_enable_i;
  assign in_busy = (state_q == ST_BUSY);
  // A real ack in the same cycle as the watchdog takes precedence.
  assign timeout = WD_EN & in_busy & (cnt_q == TIMEOUT_VAL);
  assign done    = (mem_ack_i & in_busy) | timeout;

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_q, rr_d;

  // Tie-break toward the requester that was not served last; a lone requester wins outright.
  always_comb begin
    winner = m1_enable_i;
    if (m0_enable_i && m1_enable_i) winner = rr_q;
    rr_d = rr_q;
    if (state_q == ST_IDLE && any_req) rr_d = ~winner;
  end

  // Round-robin pointer; comes out of reset favouring m1.
  always_ff @(posedge clk_i) begin
    if (!rst_i) rr_q <= 1'b1;
    else        rr_q <= rr_d;
  end
`else
  // Fixed priority: the dcache (m1) wins whenever it asks.
  always_comb begin
    winner = m1_enable_i;
  end
`endif

  // Transaction FSM: capture the winner's request, hold it, release after ack or timeout.
  always_comb begin
    state_d      = state_q;
    mem_enable_d = mem_enable_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    grant_d      = grant_q;
    err_d        = err_q;
    cnt_d        = '0;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d      = ST_BUSY;
          mem_enable_d = 1'b1;
          grant_d      = winner;
          mem_write_d  = winner ? m1_write_i : m0_write_i;
          mem_addr_d   = winner ? m1_addr_i  : m0_addr_i;
          mem_data_d   = winner ? m1_data_i  : m0_data_i;
        end
      end
      ST_BUSY: begin
        if (done) begin
          state_d      = ST_RELEASE;
          mem_enable_d = 1'b0;
          if (!mem_ack_i) err_d = 1'b1;
        end else if (WD_EN) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      // The acked requester drops its enable here, so a stale request is never regranted.
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // State and memory-side registers; reset abandons any access in flight.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= ST_IDLE;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      grant_q      <= 1'b1;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      mem_enable_q <= mem_enable_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      grant_q      <= grant_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end

  // A forced watchdog ack carries zero data; otherwise the memory's data passes straight through.
  assign rsp_data = (timeout & ~mem_ack_i) ? '0 : mem_data_i;

  assign m0_ack_o     = done & ~grant_q;
  assign m1_ack_o     = done & grant_q;
  assign m0_data_o    = rsp_data;
  assign m1_data_o    = rsp_data;
  assign mem_enable_o = mem_enable_q;
  assign mem_write_o  = mem_write_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;
  assign grant_o      = grant_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter. Requesters push the
// expected response of each request into a per-port queue. A Data_Memory
// model answers the memory port. A negedge monitor predicts each grant
// from the arbitration rules and pops and compares each ack.
module tb_mem_arbiter;

  localparam int TO = 8;
  localparam logic [31:0] NOACK_ADDR = 32'hFFFF_FF00;
  localparam logic [31:0] SLOW_ADDR  = 32'hFFFF_FE00;

  typedef struct {
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] data;
    logic [255:0] rdata;
    logic         to;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         m0_enable_i, m0_write_i, m1_enable_i, m1_write_i;
  logic [31:0]  m0_addr_i, m1_addr_i;
  logic [255:0] m0_data_i, m1_data_i;
  logic         m0_ack_o, m1_ack_o;
  logic [255:0] m0_data_o, m1_data_o;
  logic         mem_enable_o, mem_write_o, mem_ack_i;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o, mem_data_i;
  logic         grant_o, err_o;

  int   total = 0;
  int   bad   = 0;
  exp_t q0[$];
  exp_t q1[$];

  mem_arbiter #(.ADDR_W(32), .DATA_W(256), .TIMEOUT_CYC(TO), .CNT_W(8)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .m0_enable_i(m0_enable_i), .m0_write_i(m0_write_i), .m0_addr_i(m0_addr_i),
    .m0_data_i(m0_data_i), .m0_ack_o(m0_ack_o), .m0_data_o(m0_data_o),
    .m1_enable_i(m1_enable_i), .m1_write_i(m1_write_i), .m1_addr_i(m1_addr_i),
    .m1_data_i(m1_data_i), .m1_ack_o(m1_ack_o), .m1_data_o(m1_data_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
    .grant_o(grant_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin bad++; $display("FAIL %s got=%b want=%b", nm, act, exp); end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin bad++; $display("FAIL %s got=%h want=%h", nm, act, exp); end
  endtask

  task automatic chk256(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin bad++; $display("FAIL %s got=%h want=%h", nm, act, exp); end
  endtask

  // Contents the memory model returns for a read of address a.
  function automatic logic [255:0] rd_val(input logic [31:0] a);
    if (a == 32'h0000_0400) return {8{32'hDEADBEEF}};
    return {8{a ^ 32'h5A5A_0F0F}};
  endfunction

  // Expected winner: a lone requester gets it. On a tie, the round-robin
  // build serves whoever was not served last, and the fixed build serves m1.
  function automatic logic pick(input logic r0, input logic r1, input logic last);
    if (r0 && r1) begin
`ifdef ARB_ROUND_ROBIN_EN
      return (last == 1'b1) ? 1'b0 : 1'b1;
`else
      return 1'b1;
`endif
    end
    return r1 ? 1'b1 : 1'b0;
  endfunction

  // Data_Memory model: acks after a random latency, never for the no-ack addresses.
  initial begin
    bit pend;
    int lat;
    pend = 0; lat = 0;
    mem_ack_i = 1'b0; mem_data_i = '0;
    forever begin
      @(posedge clk); #1;
      mem_ack_i  = 1'b0;
      mem_data_i = {8{$urandom}};
      if (!mem_enable_o) pend = 0;
      else if (!pend) begin
        pend = 1;
        lat  = (mem_addr_o == 32'h0000_0400) ? 6 : $urandom_range(1, 5);
      end else if (mem_addr_o != NOACK_ADDR && mem_addr_o != SLOW_ADDR) begin
        lat--;
        if (lat == 0) begin
          mem_ack_i  = 1'b1;
          mem_data_i = rd_val(mem_addr_o);
          pend       = 0;
        end
      end
    end
  end

  // Issue one request on port x, wait for its ack, then drop the enable.
  task automatic do_req(input logic x, input logic wr, input logic [31:0] a, input logic [255:0] d);
    exp_t e;
    int   n;
    logic got;
    e.wr = wr; e.addr = a; e.data = d; e.to = (a == NOACK_ADDR);
    e.rdata = e.to ? '0 : rd_val(a);
    @(posedge clk); #1;
    if (x) begin
      m1_enable_i = 1'b1; m1_write_i = wr; m1_addr_i = a; m1_data_i = d; q1.push_back(e);
    end else begin
      m0_enable_i = 1'b1; m0_write_i = wr; m0_addr_i = a; m0_data_i = d; q0.push_back(e);
    end
    n = 0; got = 1'b0;
    while (!got && n < 600) begin
      @(negedge clk);
      n++;
      got = x ? m1_ack_o : m0_ack_o;
      // Once granted, scribble on the write data port; the memory must keep the captured copy.
      if (!got && wr && mem_enable_o && grant_o == x) begin
        if (x) m1_data_i = ~d; else m0_data_i = ~d;
      end
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL ack_wait port=%0d got=no_ack want=ack", x);
    end
    @(posedge clk); #1;
    if (x) m1_enable_i = 1'b0; else m0_enable_i = 1'b0;
  endtask

  // Monitor and scoreboard.
  logic pm0 = 1'b0, pm1 = 1'b0, in_txn = 1'b0, owner = 1'b1, last = 1'b0, exp_err = 1'b0;
  logic exp_w, xa;
  int   busy = 0, post_ack = 0;
  exp_t cur, e_pop;

  always @(negedge clk) begin
    if (!rst_i) begin
      q0.delete(); q1.delete();
      in_txn = 1'b0; post_ack = 0; last = 1'b0; exp_err = 1'b0;
    end else begin
      if (post_ack > 0) begin
        chk1("enable_low_after_ack", mem_enable_o, 1'b0);
        post_ack--;
      end
      if (mem_enable_o && !in_txn) begin
        exp_w = pick(pm0, pm1, last);
        chk1("grant_had_request", pm0 | pm1, 1'b1);
        chk1("grant_owner", grant_o, exp_w);
        owner = exp_w; last = exp_w; in_txn = 1'b1; busy = 0;
        if ((exp_w && q1.size() == 0) || (!exp_w && q0.size() == 0)) begin
          total++; bad++;
          $display("FAIL grant_queue got=empty want=pending_request owner=%0d", exp_w);
          cur.wr = mem_write_o; cur.addr = mem_addr_o; cur.data = mem_data_o;
        end else begin
          cur = exp_w ? q1[0] : q0[0];
          chk1("grant_write", mem_write_o, cur.wr);
          chk32("grant_addr", mem_addr_o, cur.addr);
          chk256("grant_data", mem_data_o, cur.data);
        end
      end
      if (in_txn) begin
        busy++;
        chk1("busy_enable", mem_enable_o, 1'b1);
        chk32("busy_addr_stable", mem_addr_o, cur.addr);
        chk256("busy_data_stable", mem_data_o, cur.data);
        chk1("busy_grant_stable", grant_o, owner);
      end
      if (m0_ack_o || m1_ack_o) begin
        chk1("single_ack", m0_ack_o & m1_ack_o, 1'b0);
        chk1("ack_in_txn", in_txn, 1'b1);
        xa = m1_ack_o;
        chk1("ack_owner", xa, owner);
        if ((xa && q1.size() == 0) || (!xa && q0.size() == 0)) begin
          total++; bad++;
          $display("FAIL ack_queue port=%0d got=ack want=no_ack", xa);
        end else begin
          e_pop = xa ? q1.pop_front() : q0.pop_front();
          chk256("ack_data", xa ? m1_data_o : m0_data_o, e_pop.rdata);
          if (e_pop.to) chk32("timeout_cycle", 32'(busy), 32'(TO + 1));
          chk1("err_at_ack", err_o, exp_err);
          if (e_pop.to) exp_err = 1'b1;
        end
        in_txn = 1'b0; post_ack = 2;
      end else begin
        chk1("err_flag", err_o, exp_err);
      end
    end
    pm0 = m0_enable_i;
    pm1 = m1_enable_i;
  end

  // Global time bound.
  initial begin
    #400000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "time limit");
  end

  // Directed scenarios followed by random traffic.
  initial begin
    int n;
    exp_t e;
    rst_i = 1'b0;
    m0_enable_i = 1'b0; m0_write_i = 1'b0; m0_addr_i = '0; m0_data_i = '0;
    m1_enable_i = 1'b0; m1_write_i = 1'b0; m1_addr_i = '0; m1_data_i = '0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b1;
    @(negedge clk);
    chk1("rst_enable", mem_enable_o, 1'b0);
    chk1("rst_write", mem_write_o, 1'b0);
    chk32("rst_addr", mem_addr_o, 32'h0);
    chk256("rst_data", mem_data_o, 256'h0);
    chk1("rst_grant", grant_o, 1'b1);
    chk1("rst_err", err_o, 1'b0);

    // Both request together straight out of reset.
    fork
      do_req(1'b0, 1'b0, 32'h0000_0100, '0);
      do_req(1'b1, 1'b0, 32'h0000_0200, '0);
    join

    // Single m1 read with a recognisable line.
    do_req(1'b1, 1'b0, 32'h0000_0400, '0);

    // m1 write; the data port changes during BUSY.
    do_req(1'b1, 1'b1, 32'h0000_0080, 256'h1234);

    // m1 back-to-back while m0 keeps asking.
    fork
      do_req(1'b0, 1'b0, 32'h0000_0540, '0);
      begin
        for (int i = 0; i < 4; i++) do_req(1'b1, 1'b0, 32'h0000_0600 + 32'(i * 32), '0);
      end
    join

    // Memory never answers; the next request must be served normally.
    do_req(1'b1, 1'b0, NOACK_ADDR, '0);
    do_req(1'b0, 1'b1, 32'h0000_0700, {8{32'h0BAD_F00D}});

    // Random traffic from both ports.
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          repeat ($urandom_range(0, 4)) @(posedge clk);
          do_req(1'b0, 1'($urandom_range(0, 1)), 32'($urandom_range(1, 1023)) << 5, {8{$urandom}});
        end
      end
      begin
        for (int j = 0; j < 30; j++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          do_req(1'b1, 1'($urandom_range(0, 1)), 32'($urandom_range(1, 1023)) << 5, {8{$urandom}});
        end
      end
    join

    // Reset in the third BUSY cycle of an m1 access that is never acked.
    @(posedge clk); #1;
    e.wr = 1'b0; e.addr = SLOW_ADDR; e.data = '0; e.rdata = '0; e.to = 1'b0;
    m1_enable_i = 1'b1; m1_write_i = 1'b0; m1_addr_i = SLOW_ADDR; m1_data_i = '0;
    q1.push_back(e);
    n = 0;
    while (!mem_enable_o && n < 20) begin @(negedge clk); n++; end
    chk1("reset_test_granted", mem_enable_o, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_i = 1'b0; m1_enable_i = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b1;
    @(negedge clk);
    chk1("midrst_enable", mem_enable_o, 1'b0);
    chk1("midrst_write", mem_write_o, 1'b0);
    chk32("midrst_addr", mem_addr_o, 32'h0);
    chk256("midrst_data", mem_data_o, 256'h0);
    chk1("midrst_grant", grant_o, 1'b1);
    chk1("midrst_err", err_o, 1'b0);
    chk1("midrst_m0_ack", m0_ack_o, 1'b0);
    chk1("midrst_m1_ack", m1_ack_o, 1'b0);
    repeat (3) @(negedge clk);
    chk1("midrst_idle", mem_enable_o, 1'b0);

    // Normal service after the reset.
    do_req(1'b0, 1'b0, 32'h0000_0420, '0);
    repeat (4) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
